// File: rtl/pdm_pcm_decimator.sv
// pdm_pcm_decimator: turns the 1-bit PDM microphone stream into PCM samples.
// The divided bit clock is edge-detected in the system clock domain. One bit is sampled
// per rising bclk edge, and the ones are counted over back-to-back windows of DECIM bits.
// Each window count is offered on a single-entry valid/ready hold register.
//
// Build option:
//   PCM_SIGNED_EN  defined   -> pcm = count - DECIM/2 (two's complement, silence = 0)
//                  undefined -> pcm = raw count 0..DECIM
module pdm_pcm_decimator #(
    parameter int unsigned DECIM = 64,
    parameter int unsigned W     = $clog2(DECIM) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_clk,
    input  logic         bclk,
    input  logic         mic_data,
    output logic [W-1:0] pcm,
    output logic         pcm_valid,
    input  logic         pcm_ready,
    output logic         overrun
);

    localparam int unsigned     CntW      = $clog2(DECIM);
    localparam logic [CntW-1:0] LastBit   = CntW'(DECIM - 1);
    localparam logic [W-1:0]    HalfScale = W'(DECIM / 2);

    typedef enum logic [0:0] {
        StIdle,
        StAcc
    } state_e;

    state_e state_q, state_d;

    logic            bclk_q;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    pcm_q, pcm_d;
    logic            pcm_valid_q, pcm_valid_d;
    logic            overrun_q, overrun_d;

    logic            edge_cyc;
    logic            count_bit;
    logic            win_end;
    logic            load_res;
    logic [W-1:0]    acc_sum;
    logic [W-1:0]    result;

    // Rising bclk edge seen while enabled; bclk_q tracks bclk even when disabled,
    // so a rise that happens during a pause is deliberately lost.
    assign edge_cyc = bclk & ~bclk_q & en_clk;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the first edge starts counting, after that windows run back to back.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (edge_cyc) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                state_d = StAcc;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: which edge cycles count a bit and which one closes a window.
    always_comb begin
        count_bit = 1'b0;
        win_end   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // acc and bit_cnt are zero here, so this edge becomes bit 0.
                count_bit = edge_cyc;
            end
            StAcc: begin
                count_bit = edge_cyc;
                win_end   = edge_cyc & (bit_cnt_q == LastBit);
            end
            default: begin
                count_bit = 1'b0;
                win_end   = 1'b0;
            end
        endcase
    end

    // Window accumulator and bit counter; both restart on the closing edge.
    always_comb begin
        acc_sum   = acc_q + W'(mic_data);
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (win_end) begin
            acc_d     = '0;
            bit_cnt_d = '0;
        end else if (count_bit) begin
            acc_d     = acc_sum;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // Window result in the selected number format.
    always_comb begin
`ifdef PCM_SIGNED_EN
        result = acc_sum - HalfScale;
`else
        result = acc_sum;
`endif
    end

    // Single-entry hold register: a result replaces the held sample only if that sample
    // is gone or being taken this very cycle; otherwise the result is dropped and flagged.
    always_comb begin
        load_res    = win_end & (~pcm_valid_q | pcm_ready);
        pcm_d       = pcm_q;
        pcm_valid_d = pcm_valid_q;
        if (load_res) begin
            pcm_d       = result;
            pcm_valid_d = 1'b1;
        end else if (pcm_valid_q && pcm_ready) begin
            pcm_valid_d = 1'b0;
        end
        overrun_d = overrun_q | (win_end & pcm_valid_q & ~pcm_ready);
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bclk_q      <= 1'b0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bclk_q      <= bclk;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule
